bcd_digit_writer: RTL and testbench

- Upstream feeder for the 8-digit seven-segment display controller.
- Accepts a binary value on a start pulse and converts it to BCD by iterative shift-add-3 (double dabble).
- Streams the digits into the controller's digit-write port (data_in, pos), one digit per cycle, least-significant digit first.
- Parks pos at an out-of-range value when idle, because the controller has no write enable and writes whenever pos < 8 and data_in < 10.

---
 rtl/bcd_digit_writer_if.sv | 23 ++
 rtl/bcd_digit_writer.sv | 115 +++++++++++
 tb/tb_bcd_digit_writer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_writer_if.sv
// rtl/bcd_digit_writer_if.sv - request/digit-write bundle between a host and bcd_digit_writer
// The host drives start/value; the writer drives status and the display digit-write port.
interface bcd_digit_writer_if #(
  parameter int VALUE_W = 27
);
  logic               start;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [3:0]         data_in;
  logic [3:0]         pos;

  modport master (
    output start, value,
    input  busy, done, overflow, data_in, pos
  );

  modport slave (
    input  start, value,
    output busy, done, overflow, data_in, pos
  );
endinterface

// File: rtl/bcd_digit_writer.sv
// rtl/bcd_digit_writer.sv - binary to BCD (double dabble) feeder for the 8-digit display controller
// Optional BCD_OVERFLOW_SAT_EN: an overflowing value displays as all nines.
module bcd_digit_writer #(
  parameter int DIGITS  = 8,
  parameter int VALUE_W = 27
) (
  input  logic            clock,
  input  logic            reset,
  bcd_digit_writer_if.slave bus
);
  localparam int BCD_N = (VALUE_W + 2) / 3;
  localparam int CNT_W = $clog2(VALUE_W + 1);
`ifdef BCD_OVERFLOW_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT, DONE} state_t;

  state_t             state;
  logic [VALUE_W-1:0] shift;
  logic [BCD_N*4-1:0] bcd;
  logic [BCD_N*4-1:0] bcd_adj;
  logic [BCD_N*4-1:0] bcd_next;
  logic [CNT_W-1:0]   bitcnt;
  logic [3:0]         k;
  logic               ovf_next;

  function automatic logic [3:0] emit_digit(input logic [BCD_N*4-1:0] b,
                                            input logic [3:0] idx,
                                            input logic ovf);
    if (SAT_EN && ovf)
      return 4'd9;
    return b[int'(idx)*4 +: 4];
  endfunction

  // One double-dabble step: add-3 correction folded into the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_N*4-2:0], shift[VALUE_W-1]};
    ovf_next = 1'b0;
    for (int i = 0; i < BCD_N; i++) begin
      if (i >= DIGITS && bcd_next[i*4 +: 4] != 4'd0)
        ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shift        <= '0;
      bcd          <= '0;
      bitcnt       <= '0;
      k            <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.pos      <= 4'hF;
      bus.data_in  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.pos     <= 4'hF;
          bus.data_in <= 4'd0;
          bus.done    <= 1'b0;
          bus.busy    <= 1'b0;
          if (bus.start) begin
            shift        <= bus.value;
            bcd          <= '0;
            bitcnt       <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= CONVERT;
          end
        end
        CONVERT: begin
          shift  <= shift << 1;
          bcd    <= bcd_next;
          bitcnt <= bitcnt + 1'b1;
          // Last step: the first write goes out on the very next cycle.
          if (bitcnt == CNT_W'(VALUE_W - 1)) begin
            bus.overflow <= ovf_next;
            k            <= 4'd0;
            bus.pos      <= 4'd0;
            bus.data_in  <= emit_digit(bcd_next, 4'd0, ovf_next);
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (k == 4'(DIGITS - 1)) begin
            bus.pos     <= 4'hF;
            bus.data_in <= 4'd0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end else begin
            k           <= k + 4'd1;
            bus.pos     <= k + 4'd1;
            bus.data_in <= emit_digit(bcd, k + 4'd1, bus.overflow);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_digit_writer.sv
// tb/tb_bcd_digit_writer.sv - directed self-checking bench for bcd_digit_writer
module tb_bcd_digit_writer;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  bcd_digit_writer_if #(.VALUE_W(27)) bus ();

  bcd_digit_writer #(.DIGITS(8), .VALUE_W(27)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // capture results of one conversion window
  int         wr_cnt;
  int         wr_cyc[32];
  logic [3:0] wr_pos[32];
  logic [3:0] wr_dat[32];
  int         done_cnt;
  int         done_cyc;
  int         busy_cnt;
  logic       ovf_c1;
  logic       ovf_c28;
  logic       ovf_end;

  // Starts a conversion and records 41 cycles; cycle n+1 is sampled #1 after the n-th edge
  // following the accepting edge. restart_n>0 pulses start (value 7) at that edge.
  task automatic run_capture(input logic [26:0] v, input int restart_n);
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.value = 27'h5A5A5A5;
    for (int n = 0; n <= 40; n++) begin
      if (n > 0) begin
        @(posedge clock);
        #1;
      end
      if (restart_n > 0 && n == restart_n) begin
        bus.start = 1'b0;
      end
      if (bus.pos !== 4'hF && wr_cnt < 32) begin
        wr_cyc[wr_cnt] = n + 1;
        wr_pos[wr_cnt] = bus.pos;
        wr_dat[wr_cnt] = bus.data_in;
        wr_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = n + 1;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == 0)  ovf_c1  = bus.overflow;
      if (n == 27) ovf_c28 = bus.overflow;
      if (n == 40) ovf_end = bus.overflow;
      if (restart_n > 0 && n == restart_n - 1) begin
        bus.start = 1'b1;
        bus.value = 27'd7;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.value = '0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pos !== 4'hF || bus.data_in !== 4'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pos=%h data=%h busy=%b done=%b ovf=%b, required pos=f data=0 busy=0 done=0 ovf=0",
               bus.pos, bus.data_in, bus.busy, bus.done, bus.overflow);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_normal;
    logic [3:0] exp_d[8];
    exp_d = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    run_capture(27'd12345678, 0);
    checks++;
    if (wr_cnt !== 8) begin
      errors++;
      $display("FAIL normal_write_count: got %0d, required 8", wr_cnt);
    end
    for (int i = 0; i < 8 && i < wr_cnt; i++) begin
      checks++;
      if (wr_cyc[i] !== 28 + i || wr_pos[i] !== 4'(i) || wr_dat[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL normal_write%0d: cycle=%0d pos=%0d data=%0d, required cycle=%0d pos=%0d data=%0d",
                 i, wr_cyc[i], wr_pos[i], wr_dat[i], 28 + i, i, exp_d[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 36) begin
      errors++;
      $display("FAIL normal_done: count=%0d cycle=%0d, required count=1 cycle=36", done_cnt, done_cyc);
    end
    checks++;
    if (busy_cnt !== 36) begin
      errors++;
      $display("FAIL normal_busy_cycles: got %0d, required 36", busy_cnt);
    end
    checks++;
    if (ovf_c28 !== 1'b0 || ovf_end !== 1'b0) begin
      errors++;
      $display("FAIL normal_overflow: c28=%b end=%b, required 0 0", ovf_c28, ovf_end);
    end
  endtask

  task automatic test_zero;
    run_capture(27'd0, 0);
    checks++;
    if (wr_cnt !== 8) begin
      errors++;
      $display("FAIL zero_write_count: got %0d, required 8", wr_cnt);
    end
    for (int i = 0; i < 8 && i < wr_cnt; i++) begin
      checks++;
      if (wr_pos[i] !== 4'(i) || wr_dat[i] !== 4'd0) begin
        errors++;
        $display("FAIL zero_write%0d: pos=%0d data=%0d, required pos=%0d data=0", i, wr_pos[i], wr_dat[i], i);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 36) begin
      errors++;
      $display("FAIL zero_done: count=%0d cycle=%0d, required count=1 cycle=36", done_cnt, done_cyc);
    end
  endtask

  task automatic test_overflow;
    logic [3:0] exp_v;
`ifdef BCD_OVERFLOW_SAT_EN
    exp_v = 4'd9;
`else
    exp_v = 4'd0;
`endif
    run_capture(27'd100000000, 0);
    checks++;
    if (ovf_c1 !== 1'b0 || ovf_c28 !== 1'b1 || ovf_end !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: c1=%b c28=%b end=%b, required 0 1 1", ovf_c1, ovf_c28, ovf_end);
    end
    checks++;
    if (wr_cnt !== 8) begin
      errors++;
      $display("FAIL overflow_write_count: got %0d, required 8", wr_cnt);
    end
    for (int i = 0; i < 8 && i < wr_cnt; i++) begin
      checks++;
      if (wr_pos[i] !== 4'(i) || wr_dat[i] !== exp_v) begin
        errors++;
        $display("FAIL overflow_write%0d: pos=%0d data=%0d, required pos=%0d data=%0d",
                 i, wr_pos[i], wr_dat[i], i, exp_v);
      end
    end
  endtask

  task automatic test_busy_start;
    run_capture(27'd5, 10);
    checks++;
    if (ovf_c1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_overflow_cleared: got %b, required 0", ovf_c1);
    end
    checks++;
    if (wr_cnt !== 8 || wr_dat[0] !== 4'd5 || wr_pos[0] !== 4'd0 || wr_dat[1] !== 4'd0) begin
      errors++;
      $display("FAIL busy_single_conversion: writes=%0d d0=%0d p0=%0d d1=%0d, required 8 5 0 0",
               wr_cnt, wr_dat[0], wr_pos[0], wr_dat[1]);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 36) begin
      errors++;
      $display("FAIL busy_done: count=%0d cycle=%0d, required count=1 cycle=36", done_cnt, done_cyc);
    end
  endtask

  task automatic test_abort;
    logic       found;
    int         late_writes;
    int         late_done;
    logic [3:0] exp_d[8];
    exp_d = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    found = 1'b0;
    bus.start = 1'b1;
    bus.value = 27'd12345678;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(posedge clock);
      #1;
      if (bus.pos === 4'd3) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach_pos3: pos 3 never seen within 60 cycles");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pos !== 4'hF || bus.data_in !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate: pos=%h data=%h busy=%b done=%b, required f 0 0 0",
               bus.pos, bus.data_in, bus.busy, bus.done);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    late_writes = 0;
    late_done = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock);
      #1;
      if (bus.pos !== 4'hF) late_writes++;
      if (bus.done !== 1'b0) late_done++;
    end
    checks++;
    if (late_writes !== 0 || late_done !== 0) begin
      errors++;
      $display("FAIL abort_quiet: writes=%0d done=%0d, required 0 0", late_writes, late_done);
    end
    run_capture(27'd42, 0);
    checks++;
    if (wr_cnt !== 8) begin
      errors++;
      $display("FAIL abort_restart_count: got %0d, required 8", wr_cnt);
    end
    for (int i = 0; i < 8 && i < wr_cnt; i++) begin
      checks++;
      if (wr_cyc[i] !== 28 + i || wr_pos[i] !== 4'(i) || wr_dat[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL abort_restart_write%0d: cycle=%0d pos=%0d data=%0d, required cycle=%0d pos=%0d data=%0d",
                 i, wr_cyc[i], wr_pos[i], wr_dat[i], 28 + i, i, exp_d[i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 36) begin
      errors++;
      $display("FAIL abort_restart_done: count=%0d cycle=%0d, required count=1 cycle=36", done_cnt, done_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal();
    test_zero();
    test_overflow();
    test_busy_start();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
